// File: rtl/sram_read_sched.sv
// sram_read_sched
// Round-robin scheduler that shares the single-port SRAM read controller
// among NREQ requesters. Each requester hands over a burst (base address and
// length). The scheduler splits it into single-word controller reads and
// returns each word tagged with the owner ID.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   req_valid/addr/len    per-requester burst request (sliced by index)
//   req_ready             one-hot combinational accept, high in IDLE only
//   ctl_read/ctl_addr     read strobe and address to the SRAM controller
//   ctl_done/ctl_data     controller completion flag and read data
//   rd_valid/data/id/last returned word stream
//   busy                  a burst is in progress
//   timeout_err/err_id    one-cycle abort pulse and owner of the aborted burst
//
// state     | meaning
// IDLE      | arbitrate, accept one burst
// ISSUE     | one-cycle read strobe for the current word
// WAIT_DONE | wait for ctl_done, watchdog running
// WAIT_LOW  | wait for ctl_done to drop before the next word
module sram_read_sched #(
    parameter int NREQ    = 3,
    parameter int AW      = 20,
    parameter int DW      = 16,
    parameter int LENW    = 10,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      req_ready,
    output logic                 ctl_read,
    output logic [AW-1:0]        ctl_addr,
    input  logic                 ctl_done,
    input  logic [DW-1:0]        ctl_data,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [IDW-1:0]       rd_id,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [IDW-1:0]       err_id
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_LOW} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [LENW-1:0] remaining_q, remaining_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            ctl_read_q, ctl_read_d;
    logic [AW-1:0]   ctl_addr_q, ctl_addr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [IDW-1:0]  rd_id_q, rd_id_d;
    logic            rd_last_q, rd_last_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;
    logic [IDW-1:0]  err_id_q, err_id_d;

    logic            win_found;
    int              win_idx;
    int              cand;
    logic [IDW-1:0]  win_id;
    logic [AW-1:0]   sel_addr;
    logic [LENW-1:0] sel_len;
    logic            grant;

    // Search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && j == cand && req_valid[j]) begin
                    win_found = 1'b1;
                    win_idx   = j;
                end
            end
        end
        win_id = IDW'(win_idx);
    end

    assign grant = win_found && (state_q == IDLE) && !Reset;

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (j == win_idx) begin
                sel_addr     = req_addr[j*AW +: AW];
                sel_len      = req_len[j*LENW +: LENW];
                req_ready[j] = grant;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        cur_id_d      = cur_id_q;
        wdog_d        = wdog_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        rd_id_d       = rd_id_q;
        rd_last_d     = rd_last_q;
        timeout_err_d = 1'b0;
        err_id_d      = err_id_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    cur_addr_d  = sel_addr;
                    remaining_d = sel_len;
                    cur_id_d    = win_id;
                    rr_ptr_d    = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
                    // Zero-length bursts are consumed without touching the SRAM.
                    if (sel_len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                wdog_d = wdog_q + WDW'(1);
                if (ctl_done) begin
                    rd_valid_d  = 1'b1;
                    rd_data_d   = ctl_data;
                    rd_id_d     = cur_id_q;
                    rd_last_d   = (remaining_q == LENW'(1));
                    remaining_d = remaining_q - LENW'(1);
                    cur_addr_d  = cur_addr_q + AW'(1);
                    state_d     = WAIT_LOW;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    err_id_d      = cur_id_q;
                    remaining_d   = '0;
                    state_d       = IDLE;
                end
            end
            WAIT_LOW: begin
                // A done held high for several cycles must count only once.
                if (!ctl_done) state_d = (remaining_q == '0) ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase

        // Strobe and address are registered so they line up with the ISSUE state.
        ctl_read_d = (state_d == ISSUE);
        ctl_addr_d = (state_d == ISSUE) ? cur_addr_d : ctl_addr_q;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            cur_id_q      <= '0;
            wdog_q        <= '0;
            ctl_read_q    <= 1'b0;
            ctl_addr_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_id_q       <= '0;
            rd_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            err_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            cur_id_q      <= cur_id_d;
            wdog_q        <= wdog_d;
            ctl_read_q    <= ctl_read_d;
            ctl_addr_q    <= ctl_addr_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_id_q       <= rd_id_d;
            rd_last_q     <= rd_last_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            err_id_q      <= err_id_d;
        end
    end

    assign ctl_read    = ctl_read_q;
    assign ctl_addr    = ctl_addr_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_id       = rd_id_q;
    assign rd_last     = rd_last_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign err_id      = err_id_q;

endmodule

// File: tb/tb_sram_read_sched.sv
// tb_sram_read_sched
// Directed bench for sram_read_sched. A small controller model raises done
// three cycles after each read strobe for two cycles, returning addr[15:0].
// Each bench cycle is sampled just after the falling edge; events (grants,
// reads, returned words, aborts) are logged with their cycle number and
// checked against hand-computed expectations.
module tb_sram_read_sched;

    localparam int NREQ = 3;
    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int LENW = 10;
    localparam int IDW  = 2;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*LENW-1:0] req_len = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 ctl_read;
    logic [AW-1:0]        ctl_addr;
    logic                 ctl_done = 1'b0;
    logic [DW-1:0]        ctl_data = '0;
    logic                 rd_valid;
    logic [DW-1:0]        rd_data;
    logic [IDW-1:0]       rd_id;
    logic                 rd_last;
    logic                 busy;
    logic                 timeout_err;
    logic [IDW-1:0]       err_id;

    sram_read_sched #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .LENW(LENW), .IDW(IDW), .TIMEOUT(16)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready),
        .ctl_read(ctl_read), .ctl_addr(ctl_addr),
        .ctl_done(ctl_done), .ctl_data(ctl_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
        .busy(busy), .timeout_err(timeout_err), .err_id(err_id)
    );

    always #5 Clk = ~Clk;

    // Controller model: done high on cycles +3 and +4 after the read strobe.
    logic        model_en = 1'b1;
    logic [2:0]  mt = '0;
    logic [15:0] ma = '0;
    always @(posedge Clk) begin
        if (Reset) begin
            mt       <= '0;
            ctl_done <= 1'b0;
        end else begin
            if (ctl_read) begin
                mt <= 3'd1;
                ma <= ctl_addr[15:0];
            end else if (mt != 3'd0 && mt != 3'd7) begin
                mt <= mt + 3'd1;
            end
            ctl_done <= model_en && (mt == 3'd2 || mt == 3'd3);
            ctl_data <= ma;
        end
    end

    typedef struct { int cyc; int id; } gr_ev_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } ctl_ev_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic [IDW-1:0] id; logic last; } rd_ev_t;
    typedef struct { int cyc; logic [IDW-1:0] id; logic busy; } to_ev_t;

    gr_ev_t  gr_q[$];
    ctl_ev_t ctl_q[$];
    rd_ev_t  rd_q[$];
    to_ev_t  to_q[$];

    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    int              busy_cnt = 0;
    logic [NREQ-1:0] pend = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample_grants();
        logic [NREQ-1:0] g;
        g = req_valid & req_ready & ~pend;
        for (int j = 0; j < NREQ; j++)
            if (g[j]) gr_q.push_back('{cyc, j});
        pend = pend | g;
    endtask

    // Advance one cycle: retire granted requests, then log this cycle.
    task automatic step();
        @(negedge Clk);
        req_valid = req_valid & ~pend;
        pend = '0;
        #1;
        cyc++;
        sample_grants();
        if (ctl_read)    ctl_q.push_back('{cyc, ctl_addr});
        if (rd_valid)    rd_q.push_back('{cyc, rd_data, rd_id, rd_last});
        if (timeout_err) to_q.push_back('{cyc, err_id, busy});
        if (busy)        busy_cnt++;
    endtask

    task automatic request(input int id, input logic [AW-1:0] a, input logic [LENW-1:0] l);
        req_addr[id*AW +: AW]     = a;
        req_len[id*LENW +: LENW]  = l;
        req_valid[id]             = 1'b1;
    endtask

    task automatic kick();
        #1;
        sample_grants();
    endtask

    task automatic clear_logs();
        gr_q.delete();
        ctl_q.delete();
        rd_q.delete();
        to_q.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int   idle;
        logic done;
        idle = 0;
        done = 1'b0;
        for (int n = 0; n < max && !done; n++) begin
            step();
            if (!busy && req_valid == '0 && pend == '0) idle++;
            else idle = 0;
            if (idle >= 3) done = 1'b1;
        end
        chk({tag, "_bound"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        // Reset state, with all requesters pending.
        request(0, 20'h00001, 10'd1);
        request(1, 20'h00002, 10'd1);
        request(2, 20'h00003, 10'd1);
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ctl_read", 32'(ctl_read), 32'd0);
        chk("rst_ctl_addr", 32'(ctl_addr), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_err_id", 32'(err_id), 32'd0);
        req_valid = '0;
        Reset = 1'b0;
        step();

        // 1: three-word burst from requester 0, schedule one word per 6 cycles.
        clear_logs();
        request(0, 20'h00100, 10'd3);
        kick();
        wait_idle("t1", 100);
        chk("t1_grants", 32'(gr_q.size()), 32'd1);
        chk("t1_reads", 32'(ctl_q.size()), 32'd3);
        chk("t1_words", 32'(rd_q.size()), 32'd3);
        chk("t1_issue_lat", 32'(ctl_q[0].cyc - gr_q[0].cyc), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_addr%0d", k), 32'(ctl_q[k].addr), 32'h100 + 32'(k));
            chk($sformatf("t1_issue_cyc%0d", k), 32'(ctl_q[k].cyc - ctl_q[0].cyc), 32'(6 * k));
            chk($sformatf("t1_rd_cyc%0d", k), 32'(rd_q[k].cyc - ctl_q[0].cyc), 32'(4 + 6 * k));
            chk($sformatf("t1_data%0d", k), 32'(rd_q[k].data), 32'h100 + 32'(k));
            chk($sformatf("t1_id%0d", k), 32'(rd_q[k].id), 32'd0);
            chk($sformatf("t1_last%0d", k), 32'(rd_q[k].last), (k == 2) ? 32'd1 : 32'd0);
        end

        // 2: all three pending after reset, twice; order 0,1,2 each round.
        do_reset();
        clear_logs();
        request(0, 20'h00010, 10'd1);
        request(1, 20'h00020, 10'd1);
        request(2, 20'h00030, 10'd1);
        kick();
        wait_idle("t2a", 100);
        request(0, 20'h00011, 10'd1);
        request(1, 20'h00021, 10'd1);
        request(2, 20'h00031, 10'd1);
        kick();
        wait_idle("t2b", 100);
        chk("t2_grants", 32'(gr_q.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t2_order%0d", k), 32'(gr_q[k].id), 32'(k % 3));
        chk("t2_gap", 32'(gr_q[1].cyc - gr_q[0].cyc), 32'd7);
        chk("t2_data1", 32'(rd_q[1].data), 32'h0020);
        chk("t2_id2", 32'(rd_q[2].id), 32'd2);
        chk("t2_last0", 32'(rd_q[0].last), 32'd1);

        // 3: after a grant to 1, pending 0 and 2 -> 2 first.
        do_reset();
        request(1, 20'h00070, 10'd1);
        kick();
        wait_idle("t3a", 100);
        clear_logs();
        request(0, 20'h00080, 10'd1);
        request(2, 20'h00090, 10'd1);
        kick();
        wait_idle("t3b", 100);
        chk("t3_first", 32'(gr_q[0].id), 32'd2);
        chk("t3_second", 32'(gr_q[1].id), 32'd0);
        chk("t3_data0", 32'(rd_q[0].data), 32'h0090);

        // 4: address wrap at the top of the space.
        clear_logs();
        request(2, 20'hFFFFE, 10'd3);
        kick();
        wait_idle("t4", 100);
        chk("t4_addr0", 32'(ctl_q[0].addr), 32'hFFFFE);
        chk("t4_addr1", 32'(ctl_q[1].addr), 32'hFFFFF);
        chk("t4_addr2", 32'(ctl_q[2].addr), 32'h00000);
        chk("t4_data2", 32'(rd_q[2].data), 32'h0000);
        chk("t4_last1", 32'(rd_q[1].last), 32'd0);
        chk("t4_last2", 32'(rd_q[2].last), 32'd1);
        chk("t4_id", 32'(rd_q[2].id), 32'd2);

        // 5: controller never completes -> abort after 16 wait cycles.
        clear_logs();
        model_en = 1'b0;
        request(1, 20'h00040, 10'd4);
        kick();
        wait_idle("t5a", 100);
        chk("t5_reads", 32'(ctl_q.size()), 32'd1);
        chk("t5_words", 32'(rd_q.size()), 32'd0);
        chk("t5_aborts", 32'(to_q.size()), 32'd1);
        chk("t5_err_id", 32'(to_q[0].id), 32'd1);
        chk("t5_abort_cyc", 32'(to_q[0].cyc - ctl_q[0].cyc), 32'd17);
        chk("t5_busy_at_abort", 32'(to_q[0].busy), 32'd0);
        model_en = 1'b1;
        clear_logs();
        request(0, 20'h00055, 10'd1);
        kick();
        wait_idle("t5b", 100);
        chk("t5_after_words", 32'(rd_q.size()), 32'd1);
        chk("t5_after_data", 32'(rd_q[0].data), 32'h0055);
        chk("t5_after_aborts", 32'(to_q.size()), 32'd0);

        // 6a: reset in WAIT_DONE of the second word of a five-word burst.
        clear_logs();
        request(0, 20'h00200, 10'd5);
        kick();
        for (int n = 0; n < 60 && ctl_q.size() < 2; n++) step();
        chk("t6_reached_word2", 32'(ctl_q.size()), 32'd2);
        step();
        Reset = 1'b1;
        step();
        chk("t6_rst_ctl_read", 32'(ctl_read), 32'd0);
        chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        for (int n = 0; n < 30; n++) step();
        chk("t6_reads_after", 32'(ctl_q.size()), 32'd2);
        chk("t6_words_after", 32'(rd_q.size()), 32'd1);

        // 6b: zero-length burst is accepted, issues nothing, advances rr_ptr.
        clear_logs();
        request(1, 20'h00300, 10'd0);
        kick();
        wait_idle("t6b", 50);
        chk("t6_zl_grants", 32'(gr_q.size()), 32'd1);
        chk("t6_zl_reads", 32'(ctl_q.size()), 32'd0);
        chk("t6_zl_busy", 32'(busy_cnt), 32'd0);
        clear_logs();
        request(1, 20'h00310, 10'd1);
        request(2, 20'h00320, 10'd1);
        kick();
        wait_idle("t6c", 100);
        chk("t6_rr_first", 32'(gr_q[0].id), 32'd2);
        chk("t6_rr_second", 32'(gr_q[1].id), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
